// File: rtl/spi_seq_pkg.sv
// -----------------------------------------------------------------------------
// spi_seq_pkg
// Shared types and constants for the SPI transaction sequencer.
//   seq_state_t  : sequencer FSM state (IDLE, ISSUE, WAIT, GAP), legacy 2-bit
//                  encoding kept explicit so external debug decoders still work
//   MODE_SINGLE  : one pass over addresses 0..last, then back to IDLE
//   MODE_CONT    : wrap to address 0 after last and keep going until en_i drops
// -----------------------------------------------------------------------------
package spi_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } seq_state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

endpackage

// File: rtl/spi_transaction_sequencer_if.sv
// -----------------------------------------------------------------------------
// spi_transaction_sequencer_if
// Control / SPI-handshake / register-file bundle around the sequencer.
//   master : PMOD control side plus SPI master (drives en/go/config/spi_done)
//   slave  : the sequencer itself (drives start, addr, wr_en and status)
// Signals:
//   en_i, go_i, mode_i, last_i[ADDR_W], gap_i[GAP_W], spi_done_i
//   start_o, addr_o[ADDR_W], wr_en_o, count_o[ADDR_W+1], busy_o,
//   burst_done_o, timeout_o
// -----------------------------------------------------------------------------
interface spi_transaction_sequencer_if #(
  parameter int DEPTH = 32,
  parameter int GAP_W = 8
) ();

  localparam int ADDR_W = $clog2(DEPTH);

  logic              en_i;
  logic              go_i;
  logic              mode_i;
  logic [ADDR_W-1:0] last_i;
  logic [GAP_W-1:0]  gap_i;
  logic              spi_done_i;
  logic              start_o;
  logic [ADDR_W-1:0] addr_o;
  logic              wr_en_o;
  logic [ADDR_W:0]   count_o;
  logic              busy_o;
  logic              burst_done_o;
  logic              timeout_o;

  modport master (
    output en_i, go_i, mode_i, last_i, gap_i, spi_done_i,
    input  start_o, addr_o, wr_en_o, count_o, busy_o, burst_done_o, timeout_o
  );

  modport slave (
    input  en_i, go_i, mode_i, last_i, gap_i, spi_done_i,
    output start_o, addr_o, wr_en_o, count_o, busy_o, burst_done_o, timeout_o
  );

endinterface

// File: rtl/spi_seq_timer.sv
// -----------------------------------------------------------------------------
// spi_seq_timer
// Loadable down-counter with a zero flag; it stops at zero rather than wrapping.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   load_i         : load value_i (has priority over dec_i)
//   dec_i          : decrement by one when non-zero
//   value_i [W]    : load value
//   zero_o         : counter currently equals zero
// -----------------------------------------------------------------------------
module spi_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/spi_transaction_sequencer.sv
// -----------------------------------------------------------------------------
// spi_transaction_sequencer
// Walks register addresses 0..last issuing one SPI transaction per address:
// start pulse, wait for spi_done, write strobe, optional idle gap, next address.
// Single-shot or continuous (wrap-around), with a WAIT watchdog.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   bus (slave)    : en/go/mode/last/gap/spi_done in;
//                    start/addr/wr_en/count/busy/burst_done/timeout out
// Parameters: DEPTH (register-file entries), GAP_W (gap field width),
//             TIMEOUT (max WAIT cycles, 0 = watchdog disabled)
// -----------------------------------------------------------------------------
module spi_transaction_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int GAP_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input logic                       clk_i,
  input logic                       reset_i,
  spi_transaction_sequencer_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN  = (TIMEOUT > 0);
  // Compared one bit wider so that a power-of-two DEPTH still clamps cleanly.
  localparam logic [ADDR_W:0] MAX_LAST = (ADDR_W + 1)'(DEPTH - 1);

  seq_state_t        state_q, state_d;
  logic              mode_q;
  logic [ADDR_W-1:0] last_q;
  logic [GAP_W-1:0]  gap_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              burst_done_q, burst_done_d;
  logic              timeout_q, timeout_d;
  logic              latch_cfg;
  logic              gap_load, gap_dec, gap_zero;
  logic              wd_load, wd_dec, wd_zero;
  logic              done_ok;
  seq_state_t        after_done;

  // spi_done only counts while waiting and enabled; abort beats a late done.
  assign done_ok    = bus.en_i && bus.spi_done_i && (state_q == ST_WAIT);
  // A zero gap skips the GAP state entirely.
  assign after_done = (gap_q == '0) ? ST_ISSUE : ST_GAP;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    burst_done_d = 1'b0;
    timeout_d    = timeout_q;
    latch_cfg    = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
    wd_load      = 1'b0;
    wd_dec       = 1'b0;

    if (!bus.en_i) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.go_i) begin
            state_d   = ST_ISSUE;
            addr_d    = '0;
            timeout_d = 1'b0;
            latch_cfg = 1'b1;
          end
        end
        ST_ISSUE: begin
          state_d = ST_WAIT;
          wd_load = 1'b1;
        end
        ST_WAIT: begin
          if (done_ok) begin
            count_d  = count_q + 1'b1;
            gap_load = (gap_q != '0);
            if (addr_q == last_q) begin
              burst_done_d = 1'b1;
              addr_d       = '0;
              state_d      = (mode_q == MODE_SINGLE) ? ST_IDLE : after_done;
              if (mode_q == MODE_SINGLE) gap_load = 1'b0;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = after_done;
            end
          end else if (WD_EN && wd_zero) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            addr_d    = '0;
          end else begin
            wd_dec = 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_zero) state_d = ST_ISSUE;
          else          gap_dec = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      // A new pass starts whenever ISSUE is entered at address 0.
      if ((state_d == ST_ISSUE) && (addr_d == '0)) count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_SINGLE;
      last_q       <= '0;
      gap_q        <= '0;
      addr_q       <= '0;
      count_q      <= '0;
      burst_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      burst_done_q <= burst_done_d;
      timeout_q    <= timeout_d;
      if (latch_cfg) begin
        mode_q <= bus.mode_i;
        last_q <= ({1'b0, bus.last_i} > MAX_LAST) ? MAX_LAST[ADDR_W-1:0] : bus.last_i;
        gap_q  <= bus.gap_i;
      end
    end
  end

  // Loaded with n-1 so the zero flag marks the n-th cycle of the interval.
  spi_seq_timer #(.W(GAP_W)) u_gap_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (gap_load),
    .dec_i   (gap_dec),
    .value_i (gap_q - 1'b1),
    .zero_o  (gap_zero)
  );

  spi_seq_timer #(.W(WD_W)) u_wd_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (wd_load),
    .dec_i   (wd_dec),
    .value_i (WD_W'(TIMEOUT - 1)),
    .zero_o  (wd_zero)
  );

  assign bus.start_o      = (state_q == ST_ISSUE);
  assign bus.addr_o       = addr_q;
  assign bus.wr_en_o      = done_ok;
  assign bus.count_o      = count_q;
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.burst_done_o = burst_done_q;
  assign bus.timeout_o    = timeout_q;

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_transaction_sequencer
// Builds each burst's expected timeline from the transaction timing rules
// (start = previous done + 1 + gap, write at done, burst_done one cycle later)
// and compares the DUT outputs against it every cycle.
// -----------------------------------------------------------------------------
module tb_spi_transaction_sequencer;

  localparam int DEPTH   = 6;
  localparam int GAP_W   = 8;
  localparam int TIMEOUT = 16;
  localparam int ADDR_W  = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cur_cyc      = 0;
  int   prev_count   = 0;

  spi_transaction_sequencer_if #(.DEPTH(DEPTH), .GAP_W(GAP_W)) bus_if ();

  spi_transaction_sequencer #(
    .DEPTH   (DEPTH),
    .GAP_W   (GAP_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus_if.slave)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cur_cyc, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'(bus_if.start_o), 0);
    check({tag, "_addr"},  32'(bus_if.addr_o), 0);
    check({tag, "_wr"},    32'(bus_if.wr_en_o), 0);
    check({tag, "_count"}, 32'(bus_if.count_o), 0);
    check({tag, "_busy"},  32'(bus_if.busy_o), 0);
    check({tag, "_bd"},    32'(bus_if.burst_done_o), 0);
    check({tag, "_to"},    32'(bus_if.timeout_o), 0);
  endtask

  // One burst from a go at relative cycle 0. Continuous bursts (and single
  // bursts with abort_tx >= 0) end by dropping en_i in the done cycle of the
  // final transaction; abort_done says whether spi_done is also high there.
  task automatic run_burst(input string tag, input bit mode, input int last_in,
                           input int gap, input int n_cont, input int fixed_lat,
                           input int abort_tx, input bit abort_done, input bit spurious);
    int s[$];
    int d[$];
    int a[$];
    int last_eff, n, abort_c, end_c, lat, st, ps, ndone, e_addr, e_count;
    bit done, in_wait, found, e_start, e_wr, e_bd, e_busy;

    last_eff = (last_in > DEPTH - 1) ? DEPTH - 1 : last_in;
    n = mode ? n_cont : last_eff + 1;
    if (abort_tx >= 0 && abort_tx < n) n = abort_tx + 1;
    for (int j = 0; j < n; j++) begin
      lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 12));
      st  = (j == 0) ? 1 : d[j-1] + 1 + gap;
      s.push_back(st);
      d.push_back(st + lat);
      a.push_back(j % (last_eff + 1));
    end
    abort_c = (mode || abort_tx >= 0) ? d[n-1] : -1;
    end_c   = d[n-1] + 3;
    e_count = prev_count;

    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      cur_cyc = c;
      bus_if.go_i   = (c == 0);
      bus_if.en_i   = (c != abort_c);
      bus_if.mode_i = mode;
      bus_if.last_i = ADDR_W'(last_in);
      bus_if.gap_i  = GAP_W'(gap);
      done    = 1'b0;
      in_wait = 1'b0;
      for (int j = 0; j < n; j++) begin
        if (d[j] == c) done = (c != abort_c) || abort_done;
        if (c >= s[j] + 1 && c <= d[j]) in_wait = 1'b1;
      end
      if (spurious && !in_wait && $urandom_range(0, 2) == 0) done = 1'b1;
      bus_if.spi_done_i = done;
      #1;

      e_start = 1'b0; e_wr = 1'b0; e_bd = 1'b0; found = 1'b0;
      e_addr = 0; ps = -1; ndone = 0;
      for (int j = 0; j < n; j++) begin
        if (s[j] == c) e_start = 1'b1;
        if (d[j] == c && c != abort_c) e_wr = 1'b1;
        if (a[j] == last_eff && d[j] + 1 == c && d[j] != abort_c) e_bd = 1'b1;
        if (!found && d[j] >= c) begin
          e_addr = a[j];
          found  = 1'b1;
        end
        if (a[j] == 0 && s[j] <= c) ps = s[j];
      end
      for (int j = 0; j < n; j++)
        if (ps >= 0 && d[j] >= ps && d[j] < c) ndone++;
      e_busy = (c >= 1 && c <= d[n-1]);
      if (abort_c >= 0 && c > abort_c) e_count = 0;
      else if (ps < 0)                 e_count = prev_count;
      else                             e_count = ndone;

      check({tag, "_start"}, 32'(bus_if.start_o), 32'(e_start));
      check({tag, "_wr"},    32'(bus_if.wr_en_o), 32'(e_wr));
      check({tag, "_bd"},    32'(bus_if.burst_done_o), 32'(e_bd));
      check({tag, "_busy"},  32'(bus_if.busy_o), 32'(e_busy));
      check({tag, "_addr"},  32'(bus_if.addr_o), 32'(e_addr));
      check({tag, "_count"}, 32'(bus_if.count_o), 32'(e_count));
      check({tag, "_to"},    32'(bus_if.timeout_o), 0);
    end
    prev_count = e_count;
    @(negedge clk);
    bus_if.go_i       = 1'b0;
    bus_if.en_i       = 1'b1;
    bus_if.spi_done_i = 1'b0;
  endtask

  // Watchdog expiry, timeout cleared by the next go, then async reset mid-WAIT.
  task automatic run_watchdog();
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      cur_cyc = c;
      bus_if.en_i       = 1'b1;
      bus_if.go_i       = (c == 0 || c == 22);
      bus_if.mode_i     = 1'b0;
      bus_if.last_i     = ADDR_W'(3);
      bus_if.gap_i      = '0;
      bus_if.spi_done_i = 1'b0;
      #1;
      check("wd_start", 32'(bus_if.start_o), 32'(c == 1 || c == 23));
      check("wd_busy",  32'(bus_if.busy_o), 32'((c >= 1 && c <= 17) || c >= 23));
      check("wd_to",    32'(bus_if.timeout_o), 32'(c >= 18 && c <= 22));
      check("wd_addr",  32'(bus_if.addr_o), 0);
      check("wd_bd",    32'(bus_if.burst_done_o), 0);
    end
    // Cycle 26 is mid-WAIT; reset lands well before the next rising edge.
    #10 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    prev_count = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cur_cyc = c;
      #1 check_all_zero("post_rst");
    end
  endtask

  initial begin
    bus_if.en_i       = 1'b1;
    bus_if.go_i       = 1'b0;
    bus_if.mode_i     = 1'b0;
    bus_if.last_i     = '0;
    bus_if.gap_i      = '0;
    bus_if.spi_done_i = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_burst("single4", 1'b0, 3, 0, 0, 5, -1, 1'b0, 1'b0);
    run_burst("gap4",    1'b0, 1, 4, 0, 3, -1, 1'b0, 1'b0);
    run_burst("cont3",   1'b1, 2, 2, 9, 0, -1, 1'b1, 1'b0);
    run_burst("cont3g0", 1'b1, 2, 0, 7, 0, -1, 1'b0, 1'b0);
    run_burst("clamp",   1'b0, 7, 1, 0, 0, -1, 1'b0, 1'b0);
    run_burst("abort",   1'b0, 4, 2, 0, 0, 2, 1'b1, 1'b1);
    for (int r = 0; r < 12; r++) begin
      run_burst("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 5)), int'($urandom_range(1, 9)), 0, -1,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    run_watchdog();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
